// File: rtl/sd_spi_responder_if.sv
// SPI link and block-memory read port shared by the SD responder and its host side.
// The master modport is the SPI host plus the memory that serves read data.
interface sd_spi_responder_if;
    logic        SPI_CS;
    logic        SPI_CLK;
    logic        SPI_MOSI;
    logic        SPI_MISO;
    logic [31:0] MEM_ADDR;
    logic [8:0]  MEM_INDEX;
    logic        MEM_RD;
    logic [7:0]  MEM_DATA;

    modport master (
        output SPI_CS,
        output SPI_CLK,
        output SPI_MOSI,
        input  SPI_MISO,
        input  MEM_ADDR,
        input  MEM_INDEX,
        input  MEM_RD,
        output MEM_DATA
    );

    modport slave (
        input  SPI_CS,
        input  SPI_CLK,
        input  SPI_MOSI,
        output SPI_MISO,
        output MEM_ADDR,
        output MEM_INDEX,
        output MEM_RD,
        input  MEM_DATA
    );
endinterface

// File: rtl/sd_spi_responder.sv
// SD card stand-in for SPI mode: decodes 6-byte commands, answers R1/R3/R7 and
// streams single 512-byte blocks (CMD17) from a byte-wide memory read port.
module sd_spi_responder #(
    parameter int          NAC_BYTES = 1,
    parameter logic [31:0] OCR_VALUE = 32'hC0FF8000
) (
    input  logic              CLOCK_50,
    input  logic              nRESET,
    sd_spi_responder_if.slave bus,
    output logic              CARD_IDLE,
    output logic              READ_ACTIVE,
    output logic              CMD_STROBE,
    output logic [5:0]        CMD_INDEX
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG,
        ST_CRC,
        ST_RESP,
        ST_GAP,
        ST_TOKEN,
        ST_DATA,
        ST_CRC_OUT
    } state_t;

    localparam logic [3:0] NAC_LAST = 4'(NAC_BYTES - 1);

    function automatic logic [7:0] r1_illegal(input logic idle);
        return {5'b00000, 1'b1, 1'b0, idle};
    endfunction

    function automatic logic [7:0] r1_plain(input logic idle);
        return {7'b0000000, idle};
    endfunction

    // Synchronisers and edge history
    logic        cs_meta_q, cs_sync_q;
    logic        sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic        mosi_meta_q, mosi_sync_q;
    logic        sclk_rise, sclk_fall;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  rx_byte;
    logic [31:0] arg_q, arg_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [39:0] resp_q, resp_d;
    logic [2:0]  resp_len_q, resp_len_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  load_byte;
    logic        miso_q, miso_d;
    logic        is_read_q, is_read_d;
    logic        card_idle_q, card_idle_d;
    logic        acmd_q, acmd_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic        cmd_strobe_q, cmd_strobe_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [8:0]  mem_index_q, mem_index_d;
    logic        mem_rd_q, mem_rd_d;
    logic        rd_pend_q, rd_pend_d;
    logic [7:0]  mem_data_q, mem_data_d;
    logic        read_active_q, read_active_d;

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign rx_byte   = {rx_q, mosi_sync_q};

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_d          = rx_q;
        arg_d         = arg_q;
        byte_cnt_d    = byte_cnt_q;
        resp_d        = resp_q;
        resp_len_d    = resp_len_q;
        tx_d          = tx_q;
        load_byte     = 8'hFF;
        miso_d        = miso_q;
        is_read_d     = is_read_q;
        card_idle_d   = card_idle_q;
        acmd_d        = acmd_q;
        cmd_index_d   = cmd_index_q;
        cmd_strobe_d  = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_index_d   = mem_index_q;
        mem_rd_d      = 1'b0;
        rd_pend_d     = mem_rd_q;
        mem_data_d    = rd_pend_q ? bus.MEM_DATA : mem_data_q;
        read_active_d = read_active_q;

        // Deselect wins over any SPI edge seen in the same cycle.
        if (cs_sync_q) begin
            state_d       = ST_IDLE;
            bit_cnt_d     = 3'd0;
            byte_cnt_d    = 4'd0;
            tx_d          = 8'hFF;
            miso_d        = 1'b1;
            is_read_d     = 1'b0;
            read_active_d = 1'b0;
        end else if (sclk_rise) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_byte[7:6] == 2'b01) begin
                            cmd_index_d = rx_byte[5:0];
                            byte_cnt_d  = 4'd0;
                            state_d     = ST_ARG;
                        end
                    end
                    ST_ARG: begin
                        arg_d      = {arg_q[23:0], rx_byte};
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        if (byte_cnt_q == 4'd3) begin
                            state_d = ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        cmd_strobe_d = 1'b1;
                        byte_cnt_d   = 4'd0;
                        state_d      = ST_RESP;
                        acmd_d       = 1'b0;
                        is_read_d    = 1'b0;
                        resp_len_d   = 3'd1;
                        resp_d       = {r1_illegal(card_idle_q), 32'hFFFF_FFFF};
                        case (cmd_index_q)
                            6'd0: begin
                                card_idle_d = 1'b1;
                                resp_d      = {8'h01, 32'hFFFF_FFFF};
                            end
                            6'd8: begin
                                resp_len_d = 3'd5;
                                resp_d     = {r1_plain(card_idle_q), 8'h00, 8'h00, 8'h01, arg_q[7:0]};
                            end
                            6'd55: begin
                                acmd_d = 1'b1;
                                resp_d = {r1_plain(card_idle_q), 32'hFFFF_FFFF};
                            end
                            6'd41: begin
                                if (acmd_q) begin
                                    card_idle_d = 1'b0;
                                    resp_d      = {8'h00, 32'hFFFF_FFFF};
                                end
                            end
                            6'd58: begin
                                resp_len_d = 3'd5;
                                resp_d     = {r1_plain(card_idle_q), OCR_VALUE};
                            end
                            6'd17: begin
                                if (!card_idle_q) begin
                                    resp_d        = {8'h00, 32'hFFFF_FFFF};
                                    mem_addr_d    = arg_q;
                                    read_active_d = 1'b1;
                                    is_read_d     = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end else if (sclk_fall) begin
            if (bit_cnt_q != 3'd0) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b1};
            end else begin
                // 8th falling edge: present the MSB of the next outgoing byte.
                case (state_q)
                    ST_RESP: begin
                        load_byte  = resp_q[39:32];
                        resp_d     = {resp_q[31:0], 8'hFF};
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        if (byte_cnt_q == {1'b0, resp_len_q - 3'd1}) begin
                            byte_cnt_d = 4'd0;
                            if (!is_read_q) begin
                                state_d = ST_IDLE;
                            end else if (NAC_BYTES == 0) begin
                                state_d = ST_TOKEN;
                            end else begin
                                state_d = ST_GAP;
                            end
                        end
                    end
                    ST_GAP: begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        if (byte_cnt_q == NAC_LAST) begin
                            byte_cnt_d = 4'd0;
                            state_d    = ST_TOKEN;
                        end
                    end
                    ST_TOKEN: begin
                        load_byte   = 8'hFE;
                        mem_rd_d    = 1'b1;
                        mem_index_d = 9'd0;
                        state_d     = ST_DATA;
                    end
                    ST_DATA: begin
                        // mem_data_q holds the byte fetched for mem_index_q one byte time ago.
                        load_byte = mem_data_q;
                        if (mem_index_q == 9'd511) begin
                            byte_cnt_d = 4'd0;
                            state_d    = ST_CRC_OUT;
                        end else begin
                            mem_rd_d    = 1'b1;
                            mem_index_d = mem_index_q + 9'd1;
                        end
                    end
                    ST_CRC_OUT: begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        if (byte_cnt_q == 4'd1) begin
                            byte_cnt_d    = 4'd0;
                            state_d       = ST_IDLE;
                            is_read_d     = 1'b0;
                            read_active_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
                miso_d = load_byte[7];
                tx_d   = {load_byte[6:0], 1'b1};
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge nRESET) begin
        if (!nRESET) begin
            cs_meta_q     <= 1'b1;
            cs_sync_q     <= 1'b1;
            sclk_meta_q   <= 1'b0;
            sclk_sync_q   <= 1'b0;
            sclk_prev_q   <= 1'b0;
            mosi_meta_q   <= 1'b1;
            mosi_sync_q   <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            rx_q          <= 7'h7F;
            arg_q         <= 32'd0;
            byte_cnt_q    <= 4'd0;
            resp_q        <= {40{1'b1}};
            resp_len_q    <= 3'd1;
            tx_q          <= 8'hFF;
            miso_q        <= 1'b1;
            is_read_q     <= 1'b0;
            card_idle_q   <= 1'b1;
            acmd_q        <= 1'b0;
            cmd_index_q   <= 6'd0;
            cmd_strobe_q  <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_index_q   <= 9'd0;
            mem_rd_q      <= 1'b0;
            rd_pend_q     <= 1'b0;
            mem_data_q    <= 8'hFF;
            read_active_q <= 1'b0;
        end else begin
            cs_meta_q     <= bus.SPI_CS;
            cs_sync_q     <= cs_meta_q;
            sclk_meta_q   <= bus.SPI_CLK;
            sclk_sync_q   <= sclk_meta_q;
            sclk_prev_q   <= sclk_sync_q;
            mosi_meta_q   <= bus.SPI_MOSI;
            mosi_sync_q   <= mosi_meta_q;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_q          <= rx_d;
            arg_q         <= arg_d;
            byte_cnt_q    <= byte_cnt_d;
            resp_q        <= resp_d;
            resp_len_q    <= resp_len_d;
            tx_q          <= tx_d;
            miso_q        <= miso_d;
            is_read_q     <= is_read_d;
            card_idle_q   <= card_idle_d;
            acmd_q        <= acmd_d;
            cmd_index_q   <= cmd_index_d;
            cmd_strobe_q  <= cmd_strobe_d;
            mem_addr_q    <= mem_addr_d;
            mem_index_q   <= mem_index_d;
            mem_rd_q      <= mem_rd_d;
            rd_pend_q     <= rd_pend_d;
            mem_data_q    <= mem_data_d;
            read_active_q <= read_active_d;
        end
    end

    assign bus.SPI_MISO  = miso_q;
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.MEM_INDEX = mem_index_q;
    assign bus.MEM_RD    = mem_rd_q;
    assign CARD_IDLE     = card_idle_q;
    assign READ_ACTIVE   = read_active_q;
    assign CMD_STROBE    = cmd_strobe_q;
    assign CMD_INDEX     = cmd_index_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: a mode-0 SPI host drives commands and a
// scoreboard of expected MISO bytes is checked as each response byte is clocked out.
module tb_sd_spi_responder;

    localparam int HALF = 4;

    logic       CLOCK_50 = 1'b0;
    logic       nRESET;
    logic       CARD_IDLE;
    logic       READ_ACTIVE;
    logic       CMD_STROBE;
    logic [5:0] CMD_INDEX;

    sd_spi_responder_if bus();

    sd_spi_responder #(
        .NAC_BYTES (1),
        .OCR_VALUE (32'hC0FF8000)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .nRESET      (nRESET),
        .bus         (bus),
        .CARD_IDLE   (CARD_IDLE),
        .READ_ACTIVE (READ_ACTIVE),
        .CMD_STROBE  (CMD_STROBE),
        .CMD_INDEX   (CMD_INDEX)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Registered memory: data valid the cycle after MEM_RD, filler otherwise.
    always @(posedge CLOCK_50) begin
        bus.MEM_DATA <= (bus.MEM_RD === 1'b1) ? (bus.MEM_INDEX[7:0] ^ 8'h5A) : 8'h33;
    end

    int         strobe_total = 0;
    logic [8:0] rd_idx_log[$];

    always @(negedge CLOCK_50) begin
        if (CMD_STROBE === 1'b1) strobe_total <= strobe_total + 1;
        if (bus.MEM_RD === 1'b1) rd_idx_log.push_back(bus.MEM_INDEX);
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            bus.SPI_MOSI = tx[i];
            cycles(HALF);
            bus.SPI_CLK = 1'b1;
            rx[i] = bus.SPI_MISO;
            cycles(HALF);
            bus.SPI_CLK = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] frame [6];
        logic [7:0] rx;
        frame = '{{2'b01, idx}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], crc};
        for (int i = 0; i < 6; i++) begin
            spi_byte(frame[i], rx);
            chk("miso_idle_during_cmd", 32'(rx), 32'hFF);
        end
    endtask

    task automatic drain(input int n, input string tag);
        logic [7:0] rx;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            spi_byte(8'hFF, rx);
            e = exp_q.pop_front();
            chk(tag, 32'(rx), 32'(e));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_miso"},        32'(bus.SPI_MISO),  32'd1);
        chk({tag, "_mem_rd"},      32'(bus.MEM_RD),    32'd0);
        chk({tag, "_mem_addr"},    bus.MEM_ADDR,       32'd0);
        chk({tag, "_mem_index"},   32'(bus.MEM_INDEX), 32'd0);
        chk({tag, "_card_idle"},   32'(CARD_IDLE),     32'd1);
        chk({tag, "_read_active"}, 32'(READ_ACTIVE),   32'd0);
        chk({tag, "_cmd_strobe"},  32'(CMD_STROBE),    32'd0);
        chk({tag, "_cmd_index"},   32'(CMD_INDEX),     32'd0);
    endtask

    initial begin
        repeat (120000) @(negedge CLOCK_50);
        $display("FAIL watchdog: run exceeded cycle budget (tests=%0d failed=%0d)", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         strobe_base;
        int         rd_base;
        int         bad;
        logic [7:0] rx;

        nRESET       = 1'b1;
        bus.SPI_CS   = 1'b1;
        bus.SPI_CLK  = 1'b0;
        bus.SPI_MOSI = 1'b1;
        #5 nRESET = 1'b0;
        cycles(3);
        check_reset_values("reset");

        nRESET = 1'b1;
        cycles(5);
        bus.SPI_CS = 1'b0;
        cycles(HALF);

        // CMD0
        strobe_base = strobe_total;
        send_cmd(6'd0, 32'h0000_0000, 8'h95);
        exp_q.push_back(8'h01);
        drain(1, "cmd0_r1");
        chk("cmd0_strobe_count", 32'(strobe_total - strobe_base), 32'd1);
        chk("cmd0_index", 32'(CMD_INDEX), 32'd0);

        // CMD8 echo pattern
        send_cmd(6'd8, 32'h0000_01AA, 8'h87);
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h01); exp_q.push_back(8'hAA);
        drain(5, "cmd8_r7");
        chk("cmd8_index", 32'(CMD_INDEX), 32'd8);

        // CMD55 + ACMD41 leaves idle
        send_cmd(6'd55, 32'h0000_0000, 8'h65);
        exp_q.push_back(8'h01);
        drain(1, "cmd55_r1");
        chk("idle_before_acmd41", 32'(CARD_IDLE), 32'd1);
        send_cmd(6'd41, 32'h4000_0000, 8'h77);
        chk("idle_after_acmd41_crc", 32'(CARD_IDLE), 32'd0);
        exp_q.push_back(8'h00);
        drain(1, "acmd41_r1");

        // CMD58 OCR
        send_cmd(6'd58, 32'h0000_0000, 8'hFD);
        exp_q.push_back(8'h00); exp_q.push_back(8'hC0); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80); exp_q.push_back(8'h00);
        drain(5, "cmd58_ocr");

        // CMD17 full block
        rd_base = rd_idx_log.size();
        send_cmd(6'd17, 32'h0000_0005, 8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) exp_q.push_back(8'(i) ^ 8'h5A);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        drain(3, "cmd17_head");
        chk("read_active_during_block", 32'(READ_ACTIVE), 32'd1);
        chk("mem_addr_latched", bus.MEM_ADDR, 32'd5);
        drain(514, "cmd17_data");
        chk("read_active_after_block", 32'(READ_ACTIVE), 32'd0);
        chk("mem_index_end", 32'(bus.MEM_INDEX), 32'd511);
        chk("block_rd_count", 32'(rd_idx_log.size() - rd_base), 32'd512);
        bad = 0;
        for (int i = 0; i < rd_idx_log.size() - rd_base; i++) begin
            if (rd_idx_log[rd_base + i] !== 9'(i)) bad++;
        end
        chk("block_rd_index_seq", 32'(bad), 32'd0);

        // CMD17 aborted after 100 data bytes; CS rises with the 8th falling edge
        rd_base = rd_idx_log.size();
        send_cmd(6'd17, 32'h0000_0007, 8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
        for (int i = 0; i < 100; i++) exp_q.push_back(8'(i) ^ 8'h5A);
        drain(103, "abort_data");
        bus.SPI_CS = 1'b1;
        cycles(3);
        chk("abort_miso_high", 32'(bus.SPI_MISO), 32'd1);
        chk("abort_mem_rd_low", 32'(bus.MEM_RD), 32'd0);
        chk("abort_read_active", 32'(READ_ACTIVE), 32'd0);
        cycles(20);
        chk("abort_rd_count", 32'(rd_idx_log.size() - rd_base), 32'd101);
        chk("abort_mem_index", 32'(bus.MEM_INDEX), 32'd100);
        chk("abort_mem_addr", bus.MEM_ADDR, 32'd7);

        bus.SPI_CS = 1'b0;
        cycles(HALF);
        send_cmd(6'd0, 32'h0000_0000, 8'h95);
        exp_q.push_back(8'h01);
        drain(1, "cmd0_after_abort");

        // Illegal cases while idle
        rd_base = rd_idx_log.size();
        send_cmd(6'd17, 32'h0000_0005, 8'hFF);
        exp_q.push_back(8'h05); exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        drain(4, "cmd17_idle_reject");
        chk("cmd17_idle_no_rd", 32'(rd_idx_log.size() - rd_base), 32'd0);
        chk("cmd17_idle_read_active", 32'(READ_ACTIVE), 32'd0);
        send_cmd(6'd41, 32'h4000_0000, 8'h77);
        exp_q.push_back(8'h05);
        drain(1, "cmd41_no_acmd");
        chk("cmd41_no_acmd_idle", 32'(CARD_IDLE), 32'd1);

        send_cmd(6'd55, 32'h0000_0000, 8'h65);
        exp_q.push_back(8'h01);
        drain(1, "cmd55_again");
        send_cmd(6'd41, 32'h4000_0000, 8'h77);
        exp_q.push_back(8'h00);
        drain(1, "acmd41_again");
        send_cmd(6'd63, 32'h0000_0000, 8'hFF);
        exp_q.push_back(8'h04); exp_q.push_back(8'hFF);
        drain(2, "cmd63_illegal");
        chk("cmd63_index", 32'(CMD_INDEX), 32'd63);

        // Asynchronous reset in the middle of a command
        spi_byte(8'h51, rx);
        spi_byte(8'h00, rx);
        cycles(2);
        nRESET = 1'b0;
        #1;
        check_reset_values("midcmd_reset");
        cycles(2);
        nRESET = 1'b1;
        bus.SPI_CS = 1'b1;
        cycles(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- SD-card responder for SPI mode. It is the device end of the SPI link driven by the 68k-side SPI master (SPI_CS / SPI_CLK / SPI_MOSI / SPI_MISO).
- Decodes 6-byte SD commands, returns R1/R3/R7 responses, and serves single 512-byte blocks (CMD17) from a byte-wide memory read port.
- Used as an on-board card stand-in for loader bring-up and as the bench counterpart of the master.
- Fully synchronous to CLOCK_50; SPI inputs are oversampled.

Parameters:
- NAC_BYTES, 1, number of 0xFF bytes between R1 and the 0xFE data token on CMD17 (range 0-15).
- OCR_VALUE, 32'hC0FF8000, OCR returned by CMD58.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- nRESET  in  1  asynchronous active-low reset.
- SPI_CS  in  1  chip select, active low.
- SPI_CLK  in  1  SPI clock, mode 0.
- SPI_MOSI  in  1  command data from the master.
- SPI_MISO  out  1  response data to the master.
- MEM_ADDR  out  32  block number latched from the CMD17 argument.
- MEM_INDEX  out  9  byte index within the block.
- MEM_RD  out  1  one-cycle read strobe.
- MEM_DATA  in  8  read data, valid the cycle after MEM_RD.
- CARD_IDLE  out  1  card is in the idle state (R1 bit0).
- READ_ACTIVE  out  1  a CMD17 transfer is in progress.
- CMD_STROBE  out  1  one-cycle pulse when a full command is received.
- CMD_INDEX  out  6  index of the last received command.

Behaviour:
- Reset values: SPI_MISO=1, MEM_RD=0, MEM_ADDR=0, MEM_INDEX=0, CARD_IDLE=1, READ_ACTIVE=0, CMD_STROBE=0, CMD_INDEX=0, FSM=IDLE.
- Input sync: SPI_CS, SPI_CLK and SPI_MOSI pass through 2-flop synchronisers.
  - Edge detect uses the synchronised SPI_CLK.
  - Supported only when SPI_CLK high and low phases are each ≥4 CLOCK_50 cycles. The master's slow mode (31 cycles) is covered; its high-speed mode (1 cycle) is out of scope.
- Bit timing:
  - MOSI sampled on the SPI_CLK rising edge.
  - SPI_MISO updated 1 cycle after the detected SPI_CLK falling edge.
  - The MSB of each outgoing byte is presented after the 8th falling edge of the previous byte, or on the SPI_CS falling edge.
- Byte framing: a 3-bit counter, cleared while SPI_CS is high. A byte is complete on the 8th rising edge.
- SPI_CS high, synchronised:
  - Counter cleared, FSM=IDLE, SPI_MISO=1, READ_ACTIVE=0.
  - No MEM_RD issued.
  - CARD_IDLE is retained.
- FSM states:
  - IDLE: received bytes whose top two bits are not 01 are ignored and MISO sends 0xFF. A byte matching 01xxxxxx latches CMD_INDEX and goes to ARG.
  - ARG: 4 bytes shifted MSB-first into a 32-bit argument register, then go to CRC.
  - CRC: one byte received and ignored (no CRC check). On completion, CMD_STROBE pulses for 1 cycle and the response is selected; go to RESP. R1 is sent in the next byte (Ncr=1).
  - RESP: sends R1, then the trailing bytes, MSB-first. Bytes received meanwhile are ignored. Go to IDLE when done, or to GAP for CMD17 with R1=0x00.
  - GAP: sends NAC_BYTES of 0xFF, then go to TOKEN.
  - TOKEN: sends 0xFE, then go to DATA.
  - DATA: sends 512 bytes, then go to CRC_OUT.
  - CRC_OUT: sends 0xFF, 0xFF, then go to IDLE; READ_ACTIVE falls.
- Command table, with the R1 idle bit = CARD_IDLE unless stated:
  - CMD0: R1=0x01; sets CARD_IDLE=1 and clears the ACMD flag.
  - CMD8: R1, then the 4-byte R7 = 0x00,0x00,0x01, arg[7:0].
  - CMD55: R1; sets the ACMD flag.
  - ACMD41 (CMD41 with the ACMD flag set): CARD_IDLE←0, R1=0x00.
  - CMD58: R1, then OCR_VALUE MSB-first.
  - CMD17 with CARD_IDLE=0: R1=0x00; MEM_ADDR←arg; READ_ACTIVE←1.
  - CMD17 with CARD_IDLE=1, any other index, or CMD41 without the ACMD flag: R1 = {5'b0, 1'b1 (illegal), 1'b0, CARD_IDLE}, i.e. 0x05 or 0x04. No trailing bytes.
  - Any command other than CMD55 clears the ACMD flag.
- Memory read:
  - MEM_RD pulses once per data byte, at the load point of the preceding byte (TOKEN for byte 0), with MEM_INDEX = the byte number.
  - MEM_DATA is registered on the following cycle.
  - MEM_INDEX increments after each read and is left at 511 after the block.
  - Exactly 512 MEM_RD pulses per complete block.
- Abort: SPI_CS rising mid-block stops further MEM_RD in the same cycle the synchronised CS is seen high.
- Simultaneous events: CS deassertion has priority over byte completion in the same cycle.

Test Plan:
- CS low, send 40 00 00 00 00 95 then FF -> MISO byte after CRC = 0x01; CMD_STROBE single pulse; CMD_INDEX=0.
- Send 48 00 00 01 AA 87 then 5×FF -> MISO returns 01 00 00 01 AA.
- Send CMD55 (77…) then ACMD41 (69 40 00 00 00 xx) -> R1 0x01 then 0x00; CARD_IDLE falls after the ACMD41 CRC byte. Then CMD58 -> 00 C0 FF 80 00.
- After init, send CMD17 with arg 0x00000005, memory pattern data = index[7:0] ^ 0x5A -> 00, FF, FE, 512 bytes matching the pattern, FF FF; MEM_ADDR=5; 512 MEM_RD pulses; READ_ACTIVE low afterwards.
- CMD17 before init -> R1 0x05, no FE token, zero MEM_RD. Unknown CMD63 after init -> 0x04.
- Raise CS after 100 data bytes -> MISO=1 and MEM_RD silent within 3 cycles; READ_ACTIVE=0. Next CS-low CMD0 -> 0x01. Assert nRESET mid-command -> all outputs at reset values immediately.
